// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller: funct3 codes, FSM states, data width.
package lsu_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    LOAD_DATA,
    MERGE,
    RESP
  } lsu_state_t;

endpackage

// File: rtl/lsu_byte_lane.sv
// Little-endian lane logic: extracts/extends load data and merges sub-word store data
// into a full memory word. Shared by the load and the read-modify-write store paths.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] word,
  input  logic [DATA_W-1:0] store_data,
  output logic [DATA_W-1:0] load_value,
  output logic [DATA_W-1:0] merged_word
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val    = word[{addr, 3'b000} +: 8];
    half_val    = addr[1] ? word[31:16] : word[15:0];

    load_value  = '0;
    case (funct3)
      F3_B:    load_value = {{24{byte_val[7]}}, byte_val};
      F3_H:    load_value = {{16{half_val[15]}}, half_val};
      F3_W:    load_value = word;
      F3_BU:   load_value = {24'd0, byte_val};
      F3_HU:   load_value = {16'd0, half_val};
      default: load_value = '0;
    endcase

    // Only funct3[1:0] matters here; illegal store codes never reach this path.
    merged_word = word;
    case (funct3[1:0])
      2'd0: merged_word[{addr, 3'b000} +: 8] = store_data[7:0];
      2'd1: begin
        if (addr[1]) merged_word[31:16] = store_data[15:0];
        else         merged_word[15:0]  = store_data[15:0];
      end
      default: merged_word = store_data;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store controller in front of a word-wide memory with registered read,
// synchronous write and no byte enables; sub-word stores use read-modify-write.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_t        state, state_next;
  logic [2:0]        f3_q;
  logic              we_q;
  logic [1:0]        addr_lo_q;
  logic [DATA_W-1:0] wdata_q;

  logic              accept;
  logic              f3_legal;
  logic              misaligned;
  logic              out_of_range;
  logic              acc_err;
  logic [DATA_W-1:0] load_ext;
  logic [DATA_W-1:0] merged;

  assign req_ready  = (state == IDLE) && !RST;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state == RESP);

  always_comb begin
    if (req_we) f3_legal = req_funct3 inside {F3_B, F3_H, F3_W};
    else        f3_legal = req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    misaligned   = ((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
                   ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
    out_of_range = |req_addr[31:ADDR_W+2];
    acc_err      = !f3_legal || misaligned || out_of_range;
  end

  lsu_byte_lane u_lane (
    .funct3      (f3_q),
    .addr        (addr_lo_q),
    .word        (mem_rdata),
    .store_data  (wdata_q),
    .load_value  (load_ext),
    .merged_word (merged)
  );

  // Next state plus memory write strobe; reset suppresses any pending write.
  always_comb begin
    state_next = state;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    case (state)
      IDLE: if (accept) state_next = acc_err ? RESP : ISSUE;
      ISSUE: begin
        if (!we_q) begin
          state_next = LOAD_DATA;
        end else if (f3_q == F3_W) begin
          state_next = RESP;
          mem_we     = 1'b1;
          mem_wdata  = wdata_q;
        end else begin
          state_next = MERGE;
        end
      end
      LOAD_DATA: state_next = RESP;
      MERGE: begin
        state_next = RESP;
        mem_we     = 1'b1;
        mem_wdata  = merged;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (RST) begin
      mem_we    = 1'b0;
      mem_wdata = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      f3_q       <= '0;
      we_q       <= 1'b0;
      addr_lo_q  <= '0;
      wdata_q    <= '0;
      mem_addr   <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_next;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      if (accept) begin
        f3_q      <= req_funct3;
        we_q      <= req_we;
        addr_lo_q <= req_addr[1:0];
        wdata_q   <= req_wdata;
        mem_addr  <= {{(32-ADDR_W){1'b0}}, req_addr[ADDR_W+1:2]};
        resp_err  <= acc_err;
      end
      if (state == LOAD_DATA) resp_rdata <= load_ext;
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl with a behavioural registered-read memory.
module tb_lsu_mem_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  always #5 CLK = ~CLK;

  lsu_mem_ctrl #(.ADDR_W(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  logic [31:0] mem [0:255];
  int          write_cnt [0:255];
  int          we_count = 0;
  logic [31:0] last_wdata = '0;
  int          cycle = 0;
  int          errors = 0;
  int          checks = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]       = 32'd0;
      write_cnt[i] = 0;
    end
    mem[4] = 32'h80818283;
  end

  always @(posedge CLK) begin
    cycle = cycle + 1;
    if (mem_we === 1'b1) begin
      mem[mem_addr[7:0]]       <= mem_wdata;
      write_cnt[mem_addr[7:0]] = write_cnt[mem_addr[7:0]] + 1;
      we_count                 = we_count + 1;
      last_wdata               = mem_wdata;
    end
    mem_rdata <= mem[mem_addr[7:0]];
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  always @(negedge CLK) begin
    if (resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_resp", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("resp_rdata", resp_rdata, mon_e.rdata);
        checkOutput("resp_err", {31'd0, resp_err}, {31'd0, mon_e.err});
        checkOutput("resp_latency", cycle - mon_e.acc, mon_e.lat);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge CLK);
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (req_ready !== 1'b1) checkOutput("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (sb.size() != 0) begin
      checkOutput("resp_timeout", sb.size(), 32'd0);
      sb.delete();
    end
    @(negedge CLK);
  endtask

  task automatic applyStimulus(input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input logic exp_err,
                               input int lat);
    wait_ready();
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    sb.push_back('{exp_rdata, exp_err, lat, cycle});
    @(posedge CLK);
    #1 req_valid = 1'b0;
    wait_drain();
  endtask

  initial begin
    int w0, a1, a2, low;
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w0, a1, a2, low;
    RST        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    repeat (3) @(negedge CLK);
    checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd0);
    checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rst_resp_err", {31'd0, resp_err}, 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
    checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    RST = 1'b0;

    // Loads from preloaded word 4
    w0 = we_count;
    applyStimulus(1'b0, 3'd2, 32'h10, 32'd0, 32'h80818283, 1'b0, 3);
    applyStimulus(1'b0, 3'd0, 32'h13, 32'd0, 32'hFFFFFF80, 1'b0, 3);
    applyStimulus(1'b0, 3'd4, 32'h13, 32'd0, 32'h00000080, 1'b0, 3);
    applyStimulus(1'b0, 3'd1, 32'h12, 32'd0, 32'hFFFF8081, 1'b0, 3);
    applyStimulus(1'b0, 3'd5, 32'h10, 32'd0, 32'h00008283, 1'b0, 3);
    checkOutput("load_no_write", we_count, w0);

    // Byte store via read-modify-write
    w0 = we_count;
    applyStimulus(1'b1, 3'd0, 32'h11, 32'h000000AA, 32'd0, 1'b0, 3);
    checkOutput("sb_write_pulses", we_count - w0, 32'd1);
    checkOutput("sb_wdata", last_wdata, 32'h8081AA83);
    checkOutput("sb_mem_word4", mem[4], 32'h8081AA83);
    applyStimulus(1'b0, 3'd2, 32'h10, 32'd0, 32'h8081AA83, 1'b0, 3);

    // Error cases
    w0 = we_count;
    applyStimulus(1'b1, 3'd1, 32'h13,  32'h5555, 32'd0, 1'b1, 1);
    applyStimulus(1'b0, 3'd2, 32'h402, 32'd0,    32'd0, 1'b1, 1);
    applyStimulus(1'b0, 3'd2, 32'h400, 32'd0,    32'd0, 1'b1, 1);
    applyStimulus(1'b0, 3'd3, 32'h10,  32'd0,    32'd0, 1'b1, 1);
    checkOutput("err_no_write", we_count, w0);

    // Reset during MERGE of SH 0x10
    w0 = we_count;
    wait_ready();
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'd1;
    req_addr   = 32'h10;
    req_wdata  = 32'h1234;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    checkOutput("merge_we_before_rst", {31'd0, mem_we}, 32'd1);
    RST = 1'b1;
    #1 checkOutput("rst_gates_we", {31'd0, mem_we}, 32'd0);
    @(negedge CLK);
    checkOutput("rst_ready_low", {31'd0, req_ready}, 32'd0);
    RST = 1'b0;
    #1 checkOutput("ready_after_rst", {31'd0, req_ready}, 32'd1);
    repeat (4) @(negedge CLK);
    checkOutput("rst_word4_kept", mem[4], 32'h8081AA83);
    checkOutput("rst_no_write", we_count, w0);

    // Back-to-back stores with req_valid held high
    wait_ready();
    a1         = cycle;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'h00;
    req_wdata  = 32'h11111111;
    sb.push_back('{32'd0, 1'b0, 2, a1});
    @(posedge CLK);
    @(negedge CLK);
    req_addr  = 32'h04;
    req_wdata = 32'h22222222;
    low = 0;
    while (req_ready !== 1'b1 && low < 10) begin
      low++;
      @(negedge CLK);
    end
    a2 = cycle;
    sb.push_back('{32'd0, 1'b0, 2, a2});
    checkOutput("b2b_ready_low", low, 32'd2);
    checkOutput("b2b_accept_gap", a2 - a1, 32'd3);
    @(posedge CLK);
    #1 req_valid = 1'b0;
    wait_drain();
    checkOutput("b2b_word0", mem[0], 32'h11111111);
    checkOutput("b2b_word1", mem[1], 32'h22222222);
    checkOutput("b2b_word0_writes", write_cnt[0], 32'd1);
    checkOutput("b2b_word1_writes", write_cnt[1], 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
